// File: rtl/gfx256_pkg.sv
// Shared types for the gfx256 pixel arbiter: FSM state encoding and requester limit.
package gfx256_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_ACK
  } pixarb_state_e;

  localparam int ARB_MAX_REQ = 8;

endpackage

// File: rtl/gfx256_pixel_arbiter_if.sv
// Bundle of requester-side and renderer-side signals around the pixel arbiter.
interface gfx256_pixel_arbiter_if #(
  parameter int NREQ        = 4,
  parameter int point_width = 16
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]             req_i;
  logic [NREQ*point_width-1:0] req_x_i;
  logic [NREQ*point_width-1:0] req_y_i;
  logic [NREQ*point_width-1:0] req_z_i;
  logic [NREQ*32-1:0]          req_color_i;
  logic [NREQ-1:0]             req_zen_i;
  logic [NREQ-1:0]             ack_o;
  logic                        write_o;
  logic [point_width-1:0]      pixel_x_o;
  logic [point_width-1:0]      pixel_y_o;
  logic [point_width-1:0]      pixel_z_o;
  logic [31:0]                 color_o;
  logic                        zbuffer_enable_o;
  logic                        ack_i;
  logic                        busy_o;
  logic [GW-1:0]               grant_o;
  logic                        timeout_o;

  modport slave (
    input  req_i, req_x_i, req_y_i, req_z_i, req_color_i, req_zen_i, ack_i,
    output ack_o, write_o, pixel_x_o, pixel_y_o, pixel_z_o, color_o,
           zbuffer_enable_o, busy_o, grant_o, timeout_o
  );

  modport master (
    output req_i, req_x_i, req_y_i, req_z_i, req_color_i, req_zen_i, ack_i,
    input  ack_o, write_o, pixel_x_o, pixel_y_o, pixel_z_o, color_o,
           zbuffer_enable_o, busy_o, grant_o, timeout_o
  );
endinterface

// File: rtl/gfx_rr_arbiter.sv
// Combinational round-robin picker: first set request after the last grant, modulo N.
module gfx_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 any,
  output logic [$clog2(N)-1:0] winner
);
  localparam int IW = $clog2(N);

  int          idx;
  logic [IW-1:0] sel;

  // Scan from the farthest position back toward last+1 so the nearest hit wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    sel    = '0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(last) + i) % N;
      sel = IW'(idx);
      if (req[sel]) begin
        any    = 1'b1;
        winner = sel;
      end
    end
  end
endmodule

// File: rtl/gfx256_pixel_arbiter.sv
// Round-robin arbiter sharing the gfx256 renderer among NREQ pixel sources;
// latches the winner's pixel, strobes write, waits for the renderer ack, acks the requester.
module gfx256_pixel_arbiter
  import gfx256_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int point_width = 16,
  parameter int TIMEOUT     = 1024
) (
  input logic                  clk_i,
  input logic                  rst_i,
  gfx256_pixel_arbiter_if.slave bus
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  pixarb_state_e   state, state_next;
  logic [NREQ-1:0] eligible;
  logic            any;
  logic [GW-1:0]   winner;
  logic [CW-1:0]   wdog;
  logic            write_next, busy_next;
  logic [NREQ-1:0] ack_next;

  // A requester acked this cycle may still show req high; keep it out of this decision.
  assign eligible = bus.req_i & ~bus.ack_o;

  gfx_rr_arbiter #(.N(NREQ)) u_rr (
    .req    (eligible),
    .last   (bus.grant_o),
    .any    (any),
    .winner (winner)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ARB_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:     if (any) state_next = ARB_ISSUE;
      ARB_ISSUE:    state_next = ARB_WAIT_ACK;
      ARB_WAIT_ACK: if (bus.ack_i) state_next = ARB_IDLE;
      default:      state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    write_next = (state == ARB_IDLE) && any;
    busy_next  = (state_next != ARB_IDLE);
    ack_next   = '0;
    if (state == ARB_WAIT_ACK && bus.ack_i) ack_next = NREQ'(1) << bus.grant_o;
  end

  // Registered outputs, field latch and watchdog
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.write_o          <= 1'b0;
      bus.busy_o           <= 1'b0;
      bus.ack_o            <= '0;
      bus.timeout_o        <= 1'b0;
      bus.grant_o          <= GW'(NREQ - 1);
      bus.pixel_x_o        <= '0;
      bus.pixel_y_o        <= '0;
      bus.pixel_z_o        <= '0;
      bus.color_o          <= '0;
      bus.zbuffer_enable_o <= 1'b0;
      wdog                 <= '0;
    end else begin
      bus.write_o <= write_next;
      bus.busy_o  <= busy_next;
      bus.ack_o   <= ack_next;
      if (state == ARB_IDLE && any) begin
        bus.grant_o          <= winner;
        bus.pixel_x_o        <= bus.req_x_i[int'(winner)*point_width +: point_width];
        bus.pixel_y_o        <= bus.req_y_i[int'(winner)*point_width +: point_width];
        bus.pixel_z_o        <= bus.req_z_i[int'(winner)*point_width +: point_width];
        bus.color_o          <= bus.req_color_i[int'(winner)*32 +: 32];
        bus.zbuffer_enable_o <= bus.req_zen_i[winner];
      end
      if (state == ARB_ISSUE) begin
        wdog <= '0;
      end else if (state == ARB_WAIT_ACK && wdog != CW'(TIMEOUT)) begin
        wdog <= wdog + 1'b1;
        if (wdog == CW'(TIMEOUT - 1)) bus.timeout_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gfx256_pixel_arbiter.sv
// Directed bench for gfx256_pixel_arbiter: per-cycle vector table plus a watchdog sequence.
module tb_gfx256_pixel_arbiter;
  localparam int NREQ = 4;
  localparam int PW   = 16;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gfx256_pixel_arbiter_if #(.NREQ(NREQ), .point_width(PW)) bus ();

  gfx256_pixel_arbiter #(.NREQ(NREQ), .point_width(PW), .TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic       wr;
    logic [3:0] acko;
    logic       busy;
    logic [1:0] grant;
  } vec_t;

  vec_t vecs[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic add(input logic r, input logic [3:0] rq, input logic a, input logic w,
                     input logic [3:0] ao, input logic b, input logic [1:0] g);
    vec_t v;
    v.rst = r; v.req = rq; v.ack = a; v.wr = w; v.acko = ao; v.busy = b; v.grant = g;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fields(input string tag, input logic [1:0] g);
    chk({tag, " x"},     32'(bus.pixel_x_o), 32'(10 + g));
    chk({tag, " y"},     32'(bus.pixel_y_o), 32'(20 + g));
    chk({tag, " z"},     32'(bus.pixel_z_o), 32'(5 + g));
    chk({tag, " color"}, bus.color_o, 32'hFF00FF00 + 32'(g));
    chk({tag, " zen"},   32'(bus.zbuffer_enable_o), 32'(g == 2'd0 || g == 2'd2));
  endtask

  initial begin
    bus.req_i       = '0;
    bus.ack_i       = 1'b0;
    bus.req_zen_i   = 4'b0101;
    bus.req_x_i     = '0;
    bus.req_y_i     = '0;
    bus.req_z_i     = '0;
    bus.req_color_i = '0;
    for (int n = 0; n < NREQ; n++) begin
      bus.req_x_i[n*PW +: PW]     = PW'(10 + n);
      bus.req_y_i[n*PW +: PW]     = PW'(20 + n);
      bus.req_z_i[n*PW +: PW]     = PW'(5 + n);
      bus.req_color_i[n*32 +: 32] = 32'hFF00FF00 + 32'(n);
    end

    rst = 1'b1;
    step();
    step();
    chk("reset write",   32'(bus.write_o),   0);
    chk("reset ack",     32'(bus.ack_o),     0);
    chk("reset busy",    32'(bus.busy_o),    0);
    chk("reset timeout", 32'(bus.timeout_o), 0);
    chk("reset grant",   32'(bus.grant_o),   3);
    chk("reset x",       32'(bus.pixel_x_o), 0);
    chk("reset color",   bus.color_o,        0);
    rst = 1'b0;

    // single request, ack three cycles after the write strobe
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 3);
    add(0, 4'b0001, 0, 1, 4'b0000, 1, 0);
    add(0, 4'b0001, 0, 0, 4'b0000, 1, 0);
    add(0, 4'b0001, 0, 0, 4'b0000, 1, 0);
    add(0, 4'b0001, 0, 0, 4'b0000, 1, 0);
    add(0, 4'b0001, 1, 0, 4'b0001, 0, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    // requester 1 holds req through its ack; ack in ISSUE/IDLE ignored; dropped req still acked
    add(0, 4'b0010, 0, 1, 4'b0000, 1, 1);
    add(0, 4'b0010, 0, 0, 4'b0000, 1, 1);
    add(0, 4'b0010, 1, 0, 4'b0010, 0, 1);
    add(0, 4'b0010, 0, 0, 4'b0000, 0, 1);
    add(0, 4'b0010, 0, 1, 4'b0000, 1, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 1, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 1, 1);
    add(0, 4'b0000, 1, 0, 4'b0010, 0, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 1);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 1);
    // all four requesting: rotation 0,1,2,3,0
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 3);
    for (int k = 0; k < 5; k++) begin
      add(0, 4'b1111, 0, 1, 4'b0000, 1, 2'(k));
      add(0, 4'b1111, 0, 0, 4'b0000, 1, 2'(k));
      add(0, 4'b1111, 0, 0, 4'b0000, 1, 2'(k));
      add(0, 4'b1111, 1, 0, 4'b0001 << (k % 4), 0, 2'(k));
    end
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    // grant at 2, then requesters 0 and 2 alternate
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 3);
    add(0, 4'b0100, 0, 1, 4'b0000, 1, 2);
    add(0, 4'b0100, 0, 0, 4'b0000, 1, 2);
    add(0, 4'b0100, 1, 0, 4'b0100, 0, 2);
    for (int k = 0; k < 3; k++) begin
      add(0, 4'b0101, 0, 1, 4'b0000, 1, (k == 1) ? 2'd2 : 2'd0);
      add(0, 4'b0101, 0, 0, 4'b0000, 1, (k == 1) ? 2'd2 : 2'd0);
      add(0, 4'b0101, 1, 0, (k == 1) ? 4'b0100 : 4'b0001, 0, (k == 1) ? 2'd2 : 2'd0);
    end
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    // reset while waiting for the renderer, then a stray ack
    add(0, 4'b0001, 0, 1, 4'b0000, 1, 0);
    add(0, 4'b0001, 0, 0, 4'b0000, 1, 0);
    add(1, 4'b0001, 0, 0, 4'b0000, 0, 3);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 3);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 3);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      rst       = vecs[i].rst;
      bus.req_i = vecs[i].req;
      bus.ack_i = vecs[i].ack;
      step();
      chk({tag, " write"},   32'(bus.write_o),   32'(vecs[i].wr));
      chk({tag, " ack"},     32'(bus.ack_o),     32'(vecs[i].acko));
      chk({tag, " busy"},    32'(bus.busy_o),    32'(vecs[i].busy));
      chk({tag, " grant"},   32'(bus.grant_o),   32'(vecs[i].grant));
      chk({tag, " timeout"}, 32'(bus.timeout_o), 0);
      if (vecs[i].rst) begin
        chk({tag, " rst x"},     32'(bus.pixel_x_o), 0);
        chk({tag, " rst color"}, bus.color_o,        0);
      end else if (vecs[i].busy) begin
        chk_fields(tag, vecs[i].grant);
      end
    end

    // watchdog: withhold ack past TIMEOUT, then a late ack
    rst = 1'b1; bus.req_i = '0; bus.ack_i = 1'b0;
    step();
    rst = 1'b0; bus.req_i = 4'b0001;
    step();
    chk("wd write", 32'(bus.write_o), 1);
    for (int c = 2; c <= 17; c++) begin
      step();
      chk($sformatf("wd early timeout c%0d", c), 32'(bus.timeout_o), 0);
    end
    step();
    chk("wd timeout rise", 32'(bus.timeout_o), 1);
    chk("wd still busy",   32'(bus.busy_o),    1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("wd timeout held", 32'(bus.timeout_o), 1);
    end
    bus.ack_i = 1'b1;
    step();
    chk("wd late ack",         32'(bus.ack_o),     32'h1);
    chk("wd timeout after ack", 32'(bus.timeout_o), 1);
    bus.ack_i = 1'b0; bus.req_i = '0;
    step();
    chk("wd idle busy",     32'(bus.busy_o),    0);
    chk("wd sticky",        32'(bus.timeout_o), 1);
    rst = 1'b1;
    step();
    chk("wd cleared by rst", 32'(bus.timeout_o), 0);
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
